coh_bus_ctrl: RTL and testbench
===============================

Name: coh_bus_ctrl

Overview:
- Shared snooping-bus controller for the two-core system; the bus-side end of each core's coherence interface.
- Collects read_miss / write_miss / invalidate requests from both cores and arbitrates them round-robin.
- Snoops the other core's cache, broadcasts invalidates, and returns grant plus a data-source select to the requester.
- One transaction in flight at a time.

Parameters:
- TAG_W, 11, width of the BICO/BOCI block tag bus.
- SNOOP_CYCLES, 2, maximum cycles cpu_search is held before a snoop is treated as a miss (min 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- read_miss  in  2  per-core read-miss request (bit i = core i); level, held until grant.
- write_miss  in  2  per-core write-miss request; level.
- invalidate  in  2  per-core upgrade/invalidate request; level.
- block_state  in  4  per-core block state of the requested line ([2i+1:2i]); block_state_t.
- BICO  in  2*TAG_W  per-core request tag ([TAG_W*i +: TAG_W]).
- cpu_search_found  in  2  per-core snoop hit response.
- cpu_search  out  2  snoop strobe to core i.
- BOCI  out  2*TAG_W  tag driven to core i during search/invalidate; 0 otherwise.
- grant  out  2  one-cycle grant to the requester.
- cpu_datasel  out  2  with grant: 1 = data from the other core's cache, 0 = from memory.
- invalidate_from_other_cpu  out  2  one-cycle invalidate strobe to the non-requesting core.

Behaviour:
- All outputs are Moore, decoded from registered state. Reset: every output 0, state IDLE, last_gnt = 1 (core 0 wins the first tie), found_q = 0, count = 0.
- Request of core i: req_i = read_miss[i] | write_miss[i] | invalidate[i].
- Op priority within one core: write_miss > read_miss > invalidate.
- IDLE:
  - If exactly one req_i is set, that core is selected.
  - If both are set, select the core != last_gnt.
  - Latch req_id, op, the core's BICO tag and its block_state.
  - Next state: op invalidate → INV, unless the latched block_state is M, which goes → GRANT. Otherwise → SNOOP.
- SNOOP:
  - cpu_search[o] = 1 and BOCI[o] = tag, where o = ~req_id.
  - count increments each cycle. Exit when cpu_search_found[o] is sampled 1, or when count == SNOOP_CYCLES-1.
  - On exit, found_q = cpu_search_found[o] and count clears.
  - Next state: op read_miss → GRANT; op write_miss → INV.
- INV: invalidate_from_other_cpu[o] = 1 and BOCI[o] = tag for exactly one cycle → GRANT.
- GRANT: grant[req_id] = 1 and cpu_datasel[req_id] = found_q for one cycle. last_gnt = req_id. → RELEASE.
- RELEASE:
  - Wait until req_{req_id} = 0, then → IDLE and clear found_q.
  - This prevents a held level request from being re-serviced.
  - A request from the other core stays pending and is taken in IDLE.
- Minimum latency, request asserted to grant:
  - read_miss, SNOOP_CYCLES=2, found on the first snoop cycle: 3 cycles (IDLE, SNOOP, GRANT).
  - invalidate from a core in S: 3 cycles (IDLE, INV, GRANT).
  - write_miss: adds the INV cycle.
- Boundary conditions:
  - Simultaneous requests: strict alternation on ties.
  - A request that drops before grant: the transaction still completes and the grant is ignored by the core. RELEASE exits immediately.
  - cpu_search_found asserted while cpu_search is low: ignored.
  - The non-requesting core never receives grant.
  - Reset mid-transaction: all outputs return to 0 the next cycle; no partial grant.

Decomposition:
- Shared package common:
  - block_state_t: I=2'b00, S=2'b01, M=2'b10.
  - bus_op_t: OP_RD, OP_WR, OP_INV.
  - bus_state_t: IDLE, SNOOP, INV, GRANT, RELEASE.
- Sub-module rr_arb2: 2-input round-robin arbiter holding last_gnt, with outputs sel and valid.

Test Plan:
1. Core0 read_miss, BICO0=11'h155; core1 returns found on the first search cycle → cpu_search[1]=1 with BOCI[1]=11'h155; grant[0] with cpu_datasel[0]=1 on cycle 3.
2. Core1 read_miss, core0 never returns found (SNOOP_CYCLES=2) → search held 2 cycles; grant[1]=1 with cpu_datasel[1]=0 at cycle 4.
3. Core0 write_miss tag 11'h02A, core1 not found → SNOOP 2 cycles, then invalidate_from_other_cpu[1]=1 for 1 cycle with BOCI[1]=11'h02A, then grant[0].
4. Core1 invalidate with block_state S → INV then grant[1] at cycle 3. Repeat with block_state M → no invalidate strobe; grant at cycle 2.
5. Both cores read_miss in the same cycle after reset → core0 granted first. Core0 drops its request and core1 is granted next. Then both request again → core0 wins, because last_gnt = 1.
6. Assert rst during SNOOP → cpu_search, BOCI and grant all read 0 the next cycle; a fresh request afterwards completes normally.

Source files
------------

// File: rtl/coh_bus_ctrl_pkg.sv
// coh_bus_ctrl_pkg: shared types for the two-core snooping-bus controller
package coh_bus_ctrl_pkg;
    typedef enum logic [1:0] {I = 2'b00, S = 2'b01, M = 2'b10} block_state_t;
    typedef enum logic [1:0] {OP_RD, OP_WR, OP_INV} bus_op_t;
    typedef enum logic [2:0] {IDLE, SNOOP, INV, GRANT, RELEASE} bus_state_t;
endpackage

// File: rtl/coh_bus_ctrl_if.sv
// coh_bus_ctrl_if: per-core request, snoop and grant signals between the cores and the bus controller
interface coh_bus_ctrl_if #(parameter int TAG_W = 11);
    logic [1:0]         read_miss, write_miss, invalidate, cpu_search_found;
    logic [3:0]         block_state;
    logic [2*TAG_W-1:0] BICO, BOCI;
    logic [1:0]         cpu_search, grant, cpu_datasel, invalidate_from_other_cpu;
    modport master (
        output read_miss, write_miss, invalidate, block_state, BICO, cpu_search_found,
        input  cpu_search, BOCI, grant, cpu_datasel, invalidate_from_other_cpu
    );
    modport slave (
        input  read_miss, write_miss, invalidate, block_state, BICO, cpu_search_found,
        output cpu_search, BOCI, grant, cpu_datasel, invalidate_from_other_cpu
    );
endinterface

// File: rtl/coh_bus_ctrl_rr_arb2.sv
// coh_bus_ctrl_rr_arb2: two-input round-robin arbiter; a tie goes to the core not granted last
module coh_bus_ctrl_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       upd,
    input  logic       gnt_id,
    output logic       sel,
    output logic       valid
);
    logic last_gnt_q, last_gnt_d;
    always_comb begin
        last_gnt_d = upd ? gnt_id : last_gnt_q;
        sel        = &req ? ~last_gnt_q : req[1];
        valid      = |req;
    end
    always_ff @(posedge clk) last_gnt_q <= rst ? 1'b1 : last_gnt_d;
endmodule

// File: rtl/coh_bus_ctrl.sv
// coh_bus_ctrl: two-core snooping-bus controller, one coherence transaction in flight at a time
module coh_bus_ctrl
    import coh_bus_ctrl_pkg::*;
#(
    parameter int TAG_W        = 11,
    parameter int SNOOP_CYCLES = 2
) (
    input logic           clk,
    input logic           rst,
    coh_bus_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(SNOOP_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SNOOP_CYCLES - 1);
    bus_state_t       state_q, state_d;
    bus_op_t          op_q, op_d;
    logic             req_id_q, req_id_d, found_q, found_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       req, oth;
    logic             sel, valid, found_o;
    block_state_t     sel_bs;
    assign req     = bus.read_miss | bus.write_miss | bus.invalidate;
    assign oth     = req_id_q ? 2'b01 : 2'b10;
    assign found_o = |(bus.cpu_search_found & oth);
    assign sel_bs  = block_state_t'(sel ? bus.block_state[3:2] : bus.block_state[1:0]);
    coh_bus_ctrl_rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .upd    (state_q == GRANT),
        .gnt_id (req_id_q),
        .sel    (sel),
        .valid  (valid)
    );
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        req_id_d = req_id_q;
        found_d  = found_q;
        tag_d    = tag_q;
        count_d  = count_q;
        case (state_q)
            IDLE: if (valid) begin
                req_id_d = sel;
                op_d     = bus.write_miss[sel] ? OP_WR : bus.read_miss[sel] ? OP_RD : OP_INV;
                tag_d    = sel ? bus.BICO[2*TAG_W-1:TAG_W] : bus.BICO[TAG_W-1:0];
                state_d  = op_d != OP_INV ? SNOOP : sel_bs == M ? GRANT : INV;
            end
            SNOOP: begin
                count_d = count_q + CNT_W'(1);
                if (found_o || count_q == CNT_LAST) begin
                    found_d = found_o;
                    count_d = '0;
                    state_d = op_q == OP_RD ? GRANT : INV;
                end
            end
            INV:   state_d = GRANT;
            GRANT: state_d = RELEASE;
            RELEASE: if (!(|(req & ~oth))) begin
                state_d = IDLE;
                found_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    // outputs are pure decodes of the registered transaction so nothing glitches toward the cores
    assign bus.cpu_search                = state_q == SNOOP ? oth : 2'b00;
    assign bus.invalidate_from_other_cpu = state_q == INV ? oth : 2'b00;
    assign bus.grant                     = state_q == GRANT ? ~oth : 2'b00;
    assign bus.cpu_datasel               = (state_q == GRANT && found_q) ? ~oth : 2'b00;
    assign bus.BOCI = (state_q == SNOOP || state_q == INV)
                    ? (req_id_q ? {{TAG_W{1'b0}}, tag_q} : {tag_q, {TAG_W{1'b0}}}) : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_RD;
            req_id_q <= 1'b0;
            found_q  <= 1'b0;
            tag_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            req_id_q <= req_id_d;
            found_q  <= found_d;
            tag_q    <= tag_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: tb/tb_coh_bus_ctrl.sv
// tb_coh_bus_ctrl: directed plan checks plus a randomized run against a transaction-level schedule model
module tb_coh_bus_ctrl;
    import coh_bus_ctrl_pkg::*;
    localparam int TW     = 11;
    localparam int SC     = 2;
    localparam int N_RAND = 4000;
    typedef struct packed {
        logic [1:0]      s;
        logic [2*TW-1:0] b;
        logic [1:0]      g;
        logic [1:0]      d;
        logic [1:0]      v;
    } ov_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    ov_t  exp_cur;
    ov_t  sched[$];
    logic fplan[$];
    int   mode;
    logic last_gnt, mr;
    logic [1:0] pend, granted;
    coh_bus_ctrl_if #(.TAG_W(TW)) bus ();
    coh_bus_ctrl #(.TAG_W(TW), .SNOOP_CYCLES(SC)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic ov_t ov(logic [1:0] s, logic [1:0] g, logic [1:0] d, logic [1:0] v,
                               logic [TW-1:0] t1, logic [TW-1:0] t0);
        return {s, t1, t0, g, d, v};
    endfunction

    task automatic cmp(input string nm, input ov_t a, input ov_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got search=%b boci=%h grant=%b dsel=%b inv=%b, want search=%b boci=%h grant=%b dsel=%b inv=%b",
                     nm, $time, a.s, a.b, a.g, a.d, a.v, e.s, e.b, e.g, e.d, e.v);
        end
    endtask

    task automatic check(input string nm, input ov_t e);
        cmp(nm, {bus.cpu_search, bus.BOCI, bus.grant, bus.cpu_datasel, bus.invalidate_from_other_cpu}, e);
    endtask

    task automatic cyc(input string nm, input ov_t e);
        @(negedge clk);
        check(nm, e);
    endtask

    task automatic clr();
        bus.read_miss = '0;
        bus.write_miss = '0;
        bus.invalidate = '0;
        bus.cpu_search_found = '0;
    endtask

    // Builds the whole output schedule of a transaction the moment it is accepted from IDLE.
    task automatic model_step();
        logic [1:0] req, oh, rh;
        logic [TW-1:0] tag, t1, t0;
        bus_op_t op;
        int hit, nc;
        req = bus.read_miss | bus.write_miss | bus.invalidate;
        if (mode == 0) begin
            exp_cur = '0;
            if (req != 2'b00) begin
                mr = (req == 2'b11) ? ~last_gnt : req[1];
                last_gnt = mr;
                op = bus.write_miss[mr] ? OP_WR : bus.read_miss[mr] ? OP_RD : OP_INV;
                tag = mr ? bus.BICO[2*TW-1:TW] : bus.BICO[TW-1:0];
                oh = mr ? 2'b01 : 2'b10;
                rh = ~oh;
                t1 = mr ? '0 : tag;
                t0 = mr ? tag : '0;
                hit = 0;
                if (op != OP_INV) begin
                    hit = $urandom_range(0, SC);
                    nc = (hit != 0) ? hit : SC;
                    for (int j = 1; j <= nc; j++) begin
                        sched.push_back(ov(oh, '0, '0, '0, t1, t0));
                        fplan.push_back(j == hit);
                    end
                end
                if (op == OP_WR || (op == OP_INV && bus.block_state[2*mr +: 2] != M))
                    sched.push_back(ov('0, '0, '0, oh, t1, t0));
                sched.push_back(ov('0, rh, (hit != 0) ? rh : 2'b00, '0, '0, '0));
                exp_cur = sched.pop_front();
                mode = 1;
            end
        end else if (mode == 1) begin
            if (sched.size() != 0) exp_cur = sched.pop_front();
            else begin
                exp_cur = '0;
                mode = 2;
            end
        end else begin
            exp_cur = '0;
            if (!req[mr]) mode = 0;
        end
    endtask

    initial begin
        logic [2:0] m;
        logic [1:0] rnd;
        logic f;
        clr();
        bus.BICO = '0;
        bus.block_state = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset", '0);
        rst = 1'b0;
        cyc("idle0", '0);
        bus.read_miss = 2'b01; bus.BICO = {11'h000, 11'h155}; bus.cpu_search_found = 2'b10;
        cyc("p1_snoop", ov(2'b10, '0, '0, '0, 11'h155, '0));
        cyc("p1_grant", ov('0, 2'b01, 2'b01, '0, '0, '0));
        clr();
        cyc("p1_release", '0);
        cyc("p1_idle", '0);
        bus.read_miss = 2'b10; bus.BICO = {11'h3C5, 11'h000};
        cyc("p2_snoop1", ov(2'b01, '0, '0, '0, '0, 11'h3C5));
        cyc("p2_snoop2", ov(2'b01, '0, '0, '0, '0, 11'h3C5));
        cyc("p2_grant", ov('0, 2'b10, '0, '0, '0, '0));
        clr();
        cyc("p2_release", '0);
        cyc("p2_idle", '0);
        bus.write_miss = 2'b01; bus.BICO = {11'h000, 11'h02A};
        cyc("p3_snoop1", ov(2'b10, '0, '0, '0, 11'h02A, '0));
        cyc("p3_snoop2", ov(2'b10, '0, '0, '0, 11'h02A, '0));
        cyc("p3_inv", ov('0, '0, '0, 2'b10, 11'h02A, '0));
        cyc("p3_grant", ov('0, 2'b01, '0, '0, '0, '0));
        clr();
        cyc("p3_release", '0);
        cyc("p3_idle", '0);
        bus.invalidate = 2'b10; bus.block_state = 4'b0100; bus.BICO = {11'h7FF, 11'h000};
        cyc("p4s_inv", ov('0, '0, '0, 2'b01, '0, 11'h7FF));
        cyc("p4s_grant", ov('0, 2'b10, '0, '0, '0, '0));
        clr();
        cyc("p4s_release", '0);
        cyc("p4s_idle", '0);
        bus.invalidate = 2'b10; bus.block_state = 4'b1000;
        cyc("p4m_grant", ov('0, 2'b10, '0, '0, '0, '0));
        clr();
        bus.block_state = '0;
        cyc("p4m_release", '0);
        cyc("p4m_idle", '0);
        bus.read_miss = 2'b11; bus.BICO = {11'h222, 11'h111};
        cyc("p5_c0_snoop1", ov(2'b10, '0, '0, '0, 11'h111, '0));
        cyc("p5_c0_snoop2", ov(2'b10, '0, '0, '0, 11'h111, '0));
        cyc("p5_c0_grant", ov('0, 2'b01, '0, '0, '0, '0));
        bus.read_miss = 2'b10;
        cyc("p5_release", '0);
        cyc("p5_idle", '0);
        cyc("p5_c1_snoop1", ov(2'b01, '0, '0, '0, '0, 11'h222));
        cyc("p5_c1_snoop2", ov(2'b01, '0, '0, '0, '0, 11'h222));
        cyc("p5_c1_grant", ov('0, 2'b10, '0, '0, '0, '0));
        clr();
        cyc("p5_release2", '0);
        cyc("p5_idle2", '0);
        bus.read_miss = 2'b11;
        cyc("p5_tie_c0", ov(2'b10, '0, '0, '0, 11'h111, '0));
        rst = 1'b1;
        cyc("p6_reset", '0);
        rst = 1'b0;
        clr();
        cyc("p6_idle", '0);
        bus.read_miss = 2'b01; bus.BICO = {11'h000, 11'h155}; bus.cpu_search_found = 2'b10;
        cyc("p6_snoop", ov(2'b10, '0, '0, '0, 11'h155, '0));
        cyc("p6_grant", ov('0, 2'b01, 2'b01, '0, '0, '0));
        clr();
        cyc("p6_release", '0);
        rst = 1'b1;
        mode = 0; last_gnt = 1'b1; sched.delete(); fplan.delete();
        bus.invalidate = 2'b10; bus.block_state = 4'b1000; bus.BICO = {11'h7FF, 11'h000};
        model_step();
        cmp("pin_inv_m", exp_cur, ov('0, 2'b10, '0, '0, '0, '0));
        mode = 0; sched.delete(); bus.block_state = 4'b0100;
        model_step();
        cmp("pin_inv_s", exp_cur, ov('0, '0, '0, 2'b01, '0, 11'h7FF));
        clr();
        bus.BICO = '0;
        bus.block_state = '0;
        mode = 0; last_gnt = 1'b1; sched.delete(); fplan.delete();
        pend = '0; granted = '0; exp_cur = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < N_RAND; n++) begin
            @(negedge clk);
            check("rand", exp_cur);
            for (int c = 0; c < 2; c++) begin
                if (exp_cur.g[c]) granted[c] = 1'b1;
                if (pend[c]) begin
                    if (granted[c] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 29) == 0)) begin
                        pend[c] = 1'b0;
                        granted[c] = 1'b0;
                        bus.read_miss[c] = 1'b0;
                        bus.write_miss[c] = 1'b0;
                        bus.invalidate[c] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    m = 3'($urandom_range(1, 7));
                    bus.read_miss[c] = m[0];
                    bus.write_miss[c] = m[1];
                    bus.invalidate[c] = m[2];
                    bus.BICO[c*TW +: TW] = TW'($urandom);
                    bus.block_state[2*c +: 2] = 2'($urandom_range(0, 2));
                    pend[c] = 1'b1;
                end
            end
            rnd = 2'($urandom);
            if (fplan.size() != 0) begin
                f = fplan.pop_front();
                bus.cpu_search_found = mr ? {rnd[1], f} : {f, rnd[0]};
            end else bus.cpu_search_found = rnd;
            model_step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
